// File: rtl/contador_puntaje.sv
// Score counter for the game: divided score clock, per-tick and per-event scoring with
// saturation, and a high-score register evaluated once on entry to the end-of-game state.
module contador_puntaje #(
    parameter int unsigned DIV         = 25_000_000,
    parameter int unsigned PTS_ACIERTO = 10,
    parameter int unsigned PTS_FALLA   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] presente,
    input  logic       acierto,
    input  logic       falla,
    output logic [8:0] puntos,
    output logic [8:0] record,
    output logic       clk_puntaje,
    output logic       nuevo_record
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StHold, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              clk_p_q, clk_p_d;
    logic [8:0]        puntos_q, puntos_d;
    logic [8:0]        record_q, record_d;
    logic              nuevo_q, nuevo_d;
    logic              was_done_q;
    logic              wrap;
    logic              tick;
    logic signed [11:0] suma;

    always_comb begin
        state_d = StHold;
        case (presente)
            3'd0:    state_d = StIdle;
            3'd1:    state_d = StRun;
            3'd2:    state_d = StHold;
            3'd3:    state_d = StDone;
            default: state_d = StHold;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        clk_p_d  = clk_p_q;
        puntos_d = puntos_q;
        record_d = record_q;
        nuevo_d  = 1'b0;

        wrap = (cnt_q == CntMax);
        tick = (state_q == StRun) && wrap && !clk_p_q;

        // Wide signed sum so a miss below zero or a hit above 511 can be clamped.
        suma = 12'(puntos_q) + 12'(tick)
             + (acierto ? 12'(PTS_ACIERTO) : 12'd0)
             - (falla   ? 12'(PTS_FALLA)   : 12'd0);

        case (state_q)
            StIdle: begin
                cnt_d    = '0;
                clk_p_d  = 1'b0;
                puntos_d = '0;
            end
            StRun: begin
                cnt_d   = wrap ? '0 : cnt_q + CntW'(1);
                clk_p_d = clk_p_q ^ wrap;
                if (suma < 0) begin
                    puntos_d = '0;
                end else if (suma > 12'sd511) begin
                    puntos_d = 9'd511;
                end else begin
                    puntos_d = suma[8:0];
                end
            end
            default: ;
        endcase

        // Only the first cycle spent in DONE may update the high score.
        if (state_q == StDone && !was_done_q && puntos_q > record_q) begin
            record_d = puntos_q;
            nuevo_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            clk_p_q    <= 1'b0;
            puntos_q   <= '0;
            record_q   <= '0;
            nuevo_q    <= 1'b0;
            was_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clk_p_q    <= clk_p_d;
            puntos_q   <= puntos_d;
            record_q   <= record_d;
            nuevo_q    <= nuevo_d;
            was_done_q <= (state_q == StDone);
        end
    end

    assign puntos       = puntos_q;
    assign record       = record_q;
    assign clk_puntaje  = clk_p_q;
    assign nuevo_record = nuevo_q;

endmodule
